// File: rtl/dmem_wbuf.sv
// rtl/dmem_wbuf.sv - data memory with posted-store FIFO write buffer and youngest-first store-to-load forwarding
// Optional MMIO status register enabled by defining DMEM_MMIO_STATUS_EN.
module dmem_wbuf #(
   parameter int          DEPTH_WORDS = 64,
   parameter int          WBUF_DEPTH  = 4,
   parameter logic [31:0] STATUS_ADDR = 32'h64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        MemWrite,
   input  logic [31:0]                 DataAdr,
   input  logic [31:0]                 WriteData,
   input  logic                        drain_en,
   output logic [31:0]                 ReadData,
   output logic [$clog2(WBUF_DEPTH):0] wbuf_count,
   output logic                        wbuf_empty,
   output logic                        wbuf_full,
   output logic                        overflow,
   output logic                        status_valid,
   output logic [31:0]                 status_data
);
   localparam int IW = $clog2(DEPTH_WORDS);
   localparam int PW = $clog2(WBUF_DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   mem     [DEPTH_WORDS];
   logic [IW-1:0] bufIdx  [WBUF_DEPTH];
   logic [31:0]   bufData [WBUF_DEPTH];
   logic [PW-1:0] wrPtr, rdPtr;
   logic [CW-1:0] count;
   logic [IW-1:0] adrIdx;
   logic          statusHit, storeReq, push, pop, isFull, fwdHit;
   logic [31:0]   fwdData;
   logic          unusedBits;

   assign adrIdx = DataAdr[2 +: IW];
   assign isFull = (count == CW'(WBUF_DEPTH));

`ifdef DMEM_MMIO_STATUS_EN
   logic        statusValid;
   logic [31:0] statusData;

   assign statusHit  = (DataAdr[31:2] == STATUS_ADDR[31:2]);
   assign unusedBits = ^DataAdr[1:0];

   // Status stores bypass the buffer entirely, so they can never overflow it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         statusValid <= 1'b0;
         statusData  <= '0;
      end else if (MemWrite && statusHit) begin
         statusValid <= 1'b1;
         statusData  <= WriteData;
      end
   end

   assign status_valid = statusValid;
   assign status_data  = statusData;
`else
   assign statusHit    = 1'b0;
   assign unusedBits   = ^{DataAdr[1:0], DataAdr[31:IW+2], STATUS_ADDR};
   assign status_valid = 1'b0;
   assign status_data  = '0;
`endif

   assign storeReq = MemWrite && !statusHit;
   assign pop      = drain_en && (count != '0);
   // A pop in the same edge frees the slot a full buffer needs.
   assign push     = storeReq && (!isFull || pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wrPtr <= wrPtr + PW'(1);
         if (pop)  rdPtr <= rdPtr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
         if (storeReq && !push) overflow <= 1'b1;
      end
   end

   // RAM and buffer payload carry no reset; validity comes from count.
   always_ff @(posedge clk) begin
      if (push) begin
         bufIdx[wrPtr]  <= adrIdx;
         bufData[wrPtr] <= WriteData;
      end
      if (pop) mem[bufIdx[rdPtr]] <= bufData[rdPtr];
   end

   // Walk oldest to youngest so the youngest matching entry overrides.
   always_comb begin
      fwdHit  = 1'b0;
      fwdData = '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
         if ((CW'(i) < count) && (bufIdx[rdPtr + PW'(i)] == adrIdx)) begin
            fwdHit  = 1'b1;
            fwdData = bufData[rdPtr + PW'(i)];
         end
      end
   end

   always_comb begin
      ReadData = mem[adrIdx];
      if (statusHit)   ReadData = status_data;
      else if (fwdHit) ReadData = fwdData;
   end

   assign wbuf_count = count;
   assign wbuf_empty = (count == '0);
   assign wbuf_full  = isFull;
endmodule

// File: tb/tb_dmem_wbuf.sv
// tb/tb_dmem_wbuf.sv - directed self-checking bench for dmem_wbuf
// Follows DMEM_MMIO_STATUS_EN the same way as the design.
module tb_dmem_wbuf;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemWrite = 1'b0;
   logic [31:0] DataAdr = '0;
   logic [31:0] WriteData = '0;
   logic        drain_en = 1'b0;
   logic [31:0] ReadData;
   logic [2:0]  wbuf_count;
   logic        wbuf_empty, wbuf_full, overflow, status_valid;
   logic [31:0] status_data;

   int nCompared = 0;
   int nMismatched = 0;

   dmem_wbuf dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
      .WriteData(WriteData), .drain_en(drain_en), .ReadData(ReadData),
      .wbuf_count(wbuf_count), .wbuf_empty(wbuf_empty), .wbuf_full(wbuf_full),
      .overflow(overflow), .status_valid(status_valid), .status_data(status_data)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One clock edge with the given request; inputs return to idle afterwards.
   task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic de);
      MemWrite  = w;
      DataAdr   = a;
      WriteData = d;
      drain_en  = de;
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      drain_en = 1'b0;
   endtask

   task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
      MemWrite = 1'b0;
      DataAdr  = a;
      #1;
      checkVal(tag, ReadData, exp);
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      checkVal("rst_count", 32'(wbuf_count), 32'd0);
      checkVal("rst_empty", 32'(wbuf_empty), 32'd1);
      checkVal("rst_full", 32'(wbuf_full), 32'd0);
      checkVal("rst_overflow", 32'(overflow), 32'd0);
      checkVal("rst_status_valid", 32'(status_valid), 32'd0);
      checkVal("rst_status_data", status_data, 32'd0);
      reset = 1'b0;

      // Seed RAM with known contents through the buffer.
      cyc(1, 32'h30, 32'hDEAD0030, 1);
      cyc(1, 32'h50, 32'h50505050, 1);
      cyc(1, 32'h54, 32'h54545454, 1);
      cyc(1, 32'h58, 32'h58585858, 1);
      checkVal("seed_count", 32'(wbuf_count), 32'd1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      checkVal("empty_drain_count", 32'(wbuf_count), 32'd0);
      peek("seed_ram30", 32'h30, 32'hDEAD0030);
      peek("seed_ram58", 32'h58, 32'h58585858);

      // Single store is forwarded before it drains.
      cyc(1, 32'h10, 32'hA5, 0);
      checkVal("t1_count", 32'(wbuf_count), 32'd1);
      peek("t1_fwd", 32'h10, 32'hA5);
      cyc(0, 0, 0, 1);
      checkVal("t1_drained", 32'(wbuf_empty), 32'd1);
      peek("t1_ram", 32'h10, 32'hA5);

      // Fill, then overflow.
      for (int i = 0; i < 4; i++) cyc(1, 32'h20 + 32'(4 * i), 32'(i + 1), 0);
      checkVal("t2_full", 32'(wbuf_full), 32'd1);
      checkVal("t2_count", 32'(wbuf_count), 32'd4);
      peek("t2_fwd2c", 32'h2C, 32'h4);
      cyc(1, 32'h30, 32'h99, 0);
      checkVal("t2_overflow", 32'(overflow), 32'd1);
      checkVal("t2_count_after", 32'(wbuf_count), 32'd4);
      peek("t2_dropped", 32'h30, 32'hDEAD0030);

      // Full buffer accepts a store when a pop happens at the same edge.
      pulseReset();
      checkVal("t3_rst_overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 4; i++) cyc(1, 32'h20 + 32'(4 * i), 32'(i + 1), 0);
      cyc(1, 32'h40, 32'h77, 1);
      checkVal("t3_count", 32'(wbuf_count), 32'd4);
      checkVal("t3_overflow", 32'(overflow), 32'd0);
      peek("t3_ram20", 32'h20, 32'h1);
      peek("t3_fwd40", 32'h40, 32'h77);
      repeat (4) cyc(0, 0, 0, 1);
      checkVal("t3_empty", 32'(wbuf_empty), 32'd1);
      peek("t3_ram2c", 32'h2C, 32'h4);
      peek("t3_ram40", 32'h40, 32'h77);

      // Duplicate addresses: youngest wins.
      cyc(1, 32'h8, 32'h11, 0);
      cyc(1, 32'h8, 32'h22, 0);
      peek("t4_fwd_young", 32'h8, 32'h22);
      cyc(0, 0, 0, 1);
      checkVal("t4_count1", 32'(wbuf_count), 32'd1);
      peek("t4_fwd_over_ram", 32'h8, 32'h22);
      cyc(0, 0, 0, 1);
      checkVal("t4_empty", 32'(wbuf_empty), 32'd1);
      peek("t4_ram", 32'h8, 32'h22);

      // Same-cycle load and push: old value now, new value next cycle.
      MemWrite = 1'b1; DataAdr = 32'h8; WriteData = 32'h33; drain_en = 1'b0;
      #1;
      checkVal("t4_same_cycle_old", ReadData, 32'h22);
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      checkVal("t4_next_cycle_new", ReadData, 32'h33);
      cyc(0, 0, 0, 1);
      peek("t4_alias", 32'h108, 32'h33);

      // Reset mid-drain discards entries without touching RAM.
      cyc(1, 32'h50, 32'hA, 0);
      cyc(1, 32'h54, 32'hB, 0);
      cyc(1, 32'h58, 32'hC, 0);
      checkVal("t5_count3", 32'(wbuf_count), 32'd3);
      drain_en = 1'b1;
      #3;
      reset = 1'b1;
      #1;
      checkVal("t5_async_count", 32'(wbuf_count), 32'd0);
      checkVal("t5_async_empty", 32'(wbuf_empty), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drain_en = 1'b0;
      peek("t5_ram50", 32'h50, 32'h50505050);
      peek("t5_ram54", 32'h54, 32'h54545454);
      peek("t5_ram58", 32'h58, 32'h58585858);

      // Status register store.
      cyc(1, 32'h64, 32'h7, 0);
`ifdef DMEM_MMIO_STATUS_EN
      checkVal("t6_status_valid", 32'(status_valid), 32'd1);
      checkVal("t6_status_data", status_data, 32'h7);
      checkVal("t6_count", 32'(wbuf_count), 32'd0);
      peek("t6_load", 32'h64, 32'h7);
`else
      checkVal("t6_status_valid", 32'(status_valid), 32'd0);
      checkVal("t6_status_data", status_data, 32'h0);
      checkVal("t6_count", 32'(wbuf_count), 32'd1);
      peek("t6_load", 32'h64, 32'h7);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule
